ysyx_25030085_seq_ctrl: RTL

//   Multi-cycle sequencer for the ysyx_25030085 core. It fetches each instruction over a

---
 rtl/ysyx_25030085_seq_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ysyx_25030085_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer for the ysyx_25030085 core: owns the PC and the
// latched instruction, and drives the fetch and data-memory valid/ready handshakes.
module ysyx_25030085_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req_valid,
  input  logic        if_req_ready,
  output logic [31:0] if_req_addr,
  input  logic        if_rsp_valid,
  input  logic [31:0] if_rsp_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_ebreak,
  input  logic [31:0] next_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  output logic        reg_we,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]      NOP_INST = 32'h0000_0013;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FWAIT, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT, S_FAULT
  } state_e;

  state_e           r_state;
  state_e           w_next_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_inst;
  logic [CNT_W-1:0] r_cnt;
  logic             w_timeout;

  // The last permitted waiting cycle; a response in that same cycle still wins.
  assign w_timeout = (r_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // NOTE: every signal written here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_FETCH;
      S_FETCH: if (if_req_ready) w_next_state = S_FWAIT;
      S_FWAIT: begin
        if (if_rsp_valid)   w_next_state = S_EXEC;
        else if (w_timeout) w_next_state = S_FAULT;
      end
      S_EXEC: begin
        if (is_ebreak)                w_next_state = S_HALT;
        else if (is_load || is_store) w_next_state = S_MEM;
        else                          w_next_state = S_WB;
      end
      S_MEM:   if (mem_req_ready) w_next_state = S_MWAIT;
      S_MWAIT: begin
        if (mem_rsp_valid)  w_next_state = S_WB;
        else if (w_timeout) w_next_state = S_FAULT;
      end
      S_WB:    w_next_state = S_FETCH;
      S_HALT:  w_next_state = S_HALT;
      S_FAULT: w_next_state = S_FAULT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request valids depend on state alone, so they can never drop before their ready.
  always_comb begin
    if_req_valid  = 1'b0;
    mem_req_valid = 1'b0;
    reg_we        = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;
    case (r_state)
      S_FETCH: if_req_valid  = 1'b1;
      S_MEM:   mem_req_valid = 1'b1;
      S_WB:    reg_we        = ~is_store;
      S_HALT:  halted        = 1'b1;
      S_FAULT: fault         = 1'b1;
      default: ;
    endcase
  end

  // PC moves only in WB and the instruction only in FWAIT, keeping both stable for decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc   <= RESET_PC;
      r_inst <= NOP_INST;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (if_req_ready) r_cnt <= '0;
        S_FWAIT: begin
          if (if_rsp_valid) r_inst <= if_rsp_data;
          else              r_cnt  <= r_cnt + CNT_W'(1);
        end
        S_MEM:   if (mem_req_ready) r_cnt <= '0;
        S_MWAIT: if (!mem_rsp_valid) r_cnt <= r_cnt + CNT_W'(1);
        S_WB:    r_pc <= next_pc;
        default: ;
      endcase
    end
  end

  assign if_req_addr = r_pc;
  assign pc          = r_pc;
  assign inst        = r_inst;

endmodule
